// File: rtl/prco_mem_arb_pkg.sv
// Shared encodings for the prco memory arbiter: FSM states and requester port ids.
// Imported by the arbiter, its grant picker and the bench.
package prco_mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  function automatic port_t other_port(input port_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/prco_rr_pick.sv
// Two-way grant picker: a lone request wins outright; a tie goes to B when prio_b is set,
// otherwise to the port that was not granted last.
module prco_rr_pick
  import prco_mem_arb_pkg::*;
(
  input  logic  req_a,
  input  logic  req_b,
  input  port_t last,
  input  logic  prio_b,
  output logic  grant_valid,
  output port_t grant_id
);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can infer a latch.
    grant_valid = req_a | req_b;
    grant_id    = PORT_A;
    if (req_a && req_b) begin
      grant_id = prio_b ? PORT_B : other_port(last);
    end else if (req_b) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/prco_mem_arb.sv
// Serialises port A (core LSU) and port B (UART loader) onto one single-port BRAM with a
// registered read; each access takes exactly four cycles: IDLE, ISSUE, WAIT, DONE.
module prco_mem_arb
  import prco_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter bit PRIO_B = 1'b0
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t state;
  port_t  last_grant;
  port_t  gnt_id;
  logic   gnt_we;

  logic              grant_valid;
  port_t             grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  prco_rr_pick u_pick (
    .req_a       (a_req),
    .req_b       (b_req),
    .last        (last_grant),
    .prio_b      (PRIO_B),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_we    = a_we;
    sel_addr  = a_addr;
    sel_wdata = a_wdata;
    if (grant_id == PORT_B) begin
      sel_we    = b_we;
      sel_addr  = b_addr;
      sel_wdata = b_wdata;
    end
  end

  // The memory command is loaded on the grant edge so mem_en is high in the ISSUE cycle;
  // mem_addr/mem_wdata then hold the latched request until the next grant.
  always_ff @(posedge clk50) begin
    // NOTE: state and every output register use non-blocking assignments and a synchronous
    // reset; all of them are plain flops, so each one is cleared, not only the FSM.
    if (rst) begin
      state      <= ST_IDLE;
      last_grant <= PORT_B;
      gnt_id     <= PORT_A;
      gnt_we     <= 1'b0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= '0;
      b_rdata    <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt_id     <= grant_id;
            gnt_we     <= sel_we;
            last_grant <= grant_id;
            mem_en     <= 1'b1;
            mem_we     <= sel_we;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            busy       <= 1'b1;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          // BRAM read data is valid in this cycle, one cycle after the enable.
          if (!gnt_we) begin
            if (gnt_id == PORT_A) a_rdata <= mem_rdata;
            else                  b_rdata <= mem_rdata;
          end
          a_ack <= (gnt_id == PORT_A);
          b_ack <= (gnt_id == PORT_B);
          state <= ST_DONE;
        end
        ST_DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
